// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The Ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             Ovf;
`endif

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff, Borrow
`ifdef SERIAL_SUB_OVF_EN
        , input Ovf
`endif
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff, Borrow
`ifdef SERIAL_SUB_OVF_EN
        , output Ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, Diff = A - B - Bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [IDX_W-1:0] idx;
    logic             bq;
    logic             in_ready_q;
    logic             out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    // Bit cell: two cascaded half-subtractors feeding the registered borrow.
    logic d1, bo1, d, bo2, b_next;
    assign d1     = a_sh[0] ^ b_sh[0];
    assign bo1    = ~a_sh[0] & b_sh[0];
    assign d      = d1 ^ bq;
    assign bo2    = ~d1 & bq;
    assign b_next = bo1 | bo2;

    // NOTE: a_sh/b_sh are left out of reset: every transaction reloads them
    // before use, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res         <= '0;
            bq          <= 1'b0;
            idx         <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values present before this edge, regardless of statement order.
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sh       <= bus.A;
                        b_sh       <= bus.B;
                        bq         <= bus.Bin;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d, res[WIDTH-1:1]};
                    bq   <= b_next;
                    idx  <= idx + 1'b1;
                    if (idx == IDX_W'(WIDTH - 1)) begin
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB versus borrow out of it.
                        ovf_q       <= bq ^ b_next;
`endif
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Diff      = res;
    assign bus.Borrow    = bq;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.Ovf       = ovf_q;
`endif
endmodule
